// File: rtl/softmax_pkg.sv
// Shared types and defaults for the softmax sequencer and its buffers.
package softmax_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT_EXP,
    DIV_ISSUE,
    WAIT_DIV,
    DRAIN
  } state_t;

  localparam logic [15:0] X_INIT_DEF  = 16'h26A3;
  localparam int unsigned CLASSES_DEF = 6;
  localparam int unsigned TIMEOUT_DEF = 64;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sm_vec_buf.sv
// Small register file: synchronous write port, asynchronous read port.
module sm_vec_buf #(
  parameter int unsigned DEPTH = 6,
  parameter int unsigned W     = 16,
  parameter int unsigned AW    = 3
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [W-1:0]  o_rdata
);

  logic [W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/softmax_sequencer.sv
// Sequences one softmax evaluation: logits -> exponent pipeline -> sum,
// then CLASSES divisions whose quotients drain through a valid/ready port.
module softmax_sequencer
  import softmax_pkg::*;
#(
  parameter int unsigned N       = 16,
  parameter int unsigned NNEW    = N + 6,
  parameter int unsigned CLASSES = CLASSES_DEF,
  parameter logic [N-1:0] X_INIT = N'(X_INIT_DEF),
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N-1:0]    in_z,
  output logic            exp_valid,
  output logic [N-1:0]    exp_x,
  output logic [N-1:0]    exp_y,
  output logic [N-1:0]    exp_z,
  input  logic            exp_capture,
  input  logic [N-1:0]    exp_xo,
  input  logic [N-1:0]    exp_yo,
  output logic            div_valid,
  output logic [NNEW-1:0] div_x,
  output logic [NNEW-1:0] div_y,
  output logic [N-1:0]    div_z,
  input  logic            div_capture,
  input  logic [N-1:0]    div_zo,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N-1:0]    out_prob,
  output logic [4:0]      out_idx,
  output logic            out_last,
  output logic            busy,
  output logic            err
);

  localparam int unsigned IW = idx_w(CLASSES);
  localparam int unsigned CW = $clog2(CLASSES + 1);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(CLASSES - 1);

  state_t          r_state, w_next;
  logic [CW-1:0]   r_acc_cnt, r_cap_cnt, r_dcap_cnt, r_iss_cnt, r_rd;
  logic [TW-1:0]   r_timer;
  logic [NNEW-1:0] r_sum;
  logic            r_exp_valid, r_err;
  logic [N-1:0]    r_exp_x, r_exp_z;

  logic            w_in_hs, w_exp_acc, w_div_acc, w_out_hs, w_timeout, w_clear;
  logic [N-1:0]    w_e, w_ebuf_rd, w_rbuf_rd;

  assign w_in_hs   = in_valid && in_ready;
  assign w_exp_acc = exp_capture && (r_state == LOAD || r_state == WAIT_EXP)
                     && (r_cap_cnt < CW'(CLASSES));
  assign w_div_acc = div_capture && (r_state == DIV_ISSUE || r_state == WAIT_DIV)
                     && (r_dcap_cnt < CW'(CLASSES));
  assign w_out_hs  = out_valid && out_ready;
  assign w_e       = exp_xo + exp_yo;

  always_comb begin
    w_next    = r_state;
    w_timeout = 1'b0;
    case (r_state)
      IDLE:      if (w_in_hs) w_next = LOAD;
      LOAD:      if (w_in_hs && r_acc_cnt == LAST) w_next = WAIT_EXP;
      WAIT_EXP: begin
        if (w_exp_acc && r_cap_cnt == LAST) w_next = DIV_ISSUE;
        else if (r_timer == TW'(TIMEOUT - 1)) begin
          w_timeout = 1'b1;
          w_next    = IDLE;
        end
      end
      // A zero-latency divider may complete on the final issue cycle.
      DIV_ISSUE: if (r_iss_cnt == LAST)
                   w_next = (w_div_acc && r_dcap_cnt == LAST) ? DRAIN : WAIT_DIV;
      WAIT_DIV: begin
        if (w_div_acc && r_dcap_cnt == LAST) w_next = DRAIN;
        else if (r_timer == TW'(TIMEOUT - 1)) begin
          w_timeout = 1'b1;
          w_next    = IDLE;
        end
      end
      DRAIN:     if (w_out_hs && r_rd == LAST) w_next = IDLE;
      default:   w_next = IDLE;
    endcase
  end

  assign w_clear = w_timeout || (r_state == DRAIN && w_next == IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_err       <= 1'b0;
      r_exp_valid <= 1'b0;
      r_exp_x     <= '0;
      r_exp_z     <= '0;
      r_timer     <= '0;
      r_acc_cnt   <= '0;
      r_cap_cnt   <= '0;
      r_dcap_cnt  <= '0;
      r_iss_cnt   <= '0;
      r_rd        <= '0;
      r_sum       <= '0;
    end else begin
      r_state     <= w_next;
      r_err       <= w_timeout;
      r_exp_valid <= w_in_hs;
      if (w_in_hs) begin
        r_exp_x <= X_INIT;
        r_exp_z <= in_z;
      end
      if (w_next != r_state)                             r_timer <= '0;
      else if (r_state == WAIT_EXP || r_state == WAIT_DIV) r_timer <= r_timer + 1'b1;
      if (w_clear) begin
        r_acc_cnt  <= '0;
        r_cap_cnt  <= '0;
        r_dcap_cnt <= '0;
        r_iss_cnt  <= '0;
        r_rd       <= '0;
        r_sum      <= '0;
      end else begin
        if (w_in_hs) r_acc_cnt <= r_acc_cnt + 1'b1;
        if (w_exp_acc) begin
          r_cap_cnt <= r_cap_cnt + 1'b1;
          r_sum     <= r_sum + NNEW'(w_e);
        end
        if (r_state == DIV_ISSUE) r_iss_cnt <= r_iss_cnt + 1'b1;
        if (w_div_acc)            r_dcap_cnt <= r_dcap_cnt + 1'b1;
        if (w_out_hs)             r_rd <= r_rd + 1'b1;
      end
    end
  end

  sm_vec_buf #(.DEPTH(CLASSES), .W(N), .AW(IW)) ebuf (
    .clk     (clk),
    .i_we    (w_exp_acc),
    .i_waddr (IW'(r_cap_cnt)),
    .i_wdata (w_e),
    .i_raddr (IW'(r_iss_cnt)),
    .o_rdata (w_ebuf_rd)
  );

  sm_vec_buf #(.DEPTH(CLASSES), .W(N), .AW(IW)) rbuf (
    .clk     (clk),
    .i_we    (w_div_acc),
    .i_waddr (IW'(r_dcap_cnt)),
    .i_wdata (div_zo),
    .i_raddr (IW'(r_rd)),
    .o_rdata (w_rbuf_rd)
  );

  assign in_ready  = (r_state == IDLE) || (r_state == LOAD);
  assign busy      = (r_state != IDLE);
  assign err       = r_err;
  assign exp_valid = r_exp_valid;
  assign exp_x     = r_exp_x;
  assign exp_y     = '0;
  assign exp_z     = r_exp_z;
  assign div_valid = (r_state == DIV_ISSUE);
  assign div_x     = div_valid ? r_sum : '0;
  assign div_y     = div_valid ? NNEW'(w_ebuf_rd) : '0;
  assign div_z     = '0;
  assign out_valid = (r_state == DRAIN);
  assign out_prob  = out_valid ? w_rbuf_rd : '0;
  assign out_idx   = out_valid ? 5'(r_rd) : '0;
  assign out_last  = out_valid && (r_rd == LAST);

endmodule
